// File: rtl/serial_to_parallel_rx_l1.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_rx_l1
//
// Bit-serial receiver front end. Shifts the serial stream (MSB of each byte
// first) into an 8-bit window, hunts for the comma/idle byte to find the byte
// boundary, and once BC_NEEDED consecutive aligned commas have been seen it
// locks the boundary and presents each received byte to the next stage.
//
// Ports
//   clk_32f    in   1   bit-rate clock, all logic on its rising edge
//   reset_L    in   1   asynchronous active-low reset
//   data_in    in   1   serial stream, MSB first
//   data_out   out  8   last captured byte (8'h00 while searching)
//   valid_out  out  1   data_out holds a payload (non-comma) byte
//   active     out  1   byte alignment achieved
//   byte_count out 16   saturating count of payload bytes
//                       (only when STP_BYTE_COUNT_EN is defined)
//
// Parameters
//   COM_CHAR   comma/idle byte used for alignment
//   BC_NEEDED  consecutive aligned commas required to lock (1..15)
//
// Optional feature macro: STP_BYTE_COUNT_EN
// -----------------------------------------------------------------------------
module serial_to_parallel_rx_l1 #(
    parameter logic [7:0]  COM_CHAR  = 8'hBC,
    parameter int unsigned BC_NEEDED = 4
) (
    input  logic        clk_32f,
    input  logic        reset_L,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        active
`ifdef STP_BYTE_COUNT_EN
    ,
    output logic [15:0] byte_count
`endif
);

    typedef enum logic {
        SEARCH = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic [3:0] BC_TARGET = 4'(BC_NEEDED);

    state_e      state_q,   state_d;
    logic [7:0]  shift_q,   shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [7:0]  data_q,    data_d;
    logic        valid_q,   valid_d;
    logic        active_q,  active_d;

    logic [7:0]  window_s;
    logic        boundary_s;
    logic        is_com_s;
    logic [3:0]  com_inc_s;

    // Next-state logic for the shifter, bit counter, comma counter and outputs.
    always_comb begin
        window_s   = {shift_q[6:0], data_in};
        boundary_s = (bit_cnt_q == 3'd7);
        is_com_s   = (window_s == COM_CHAR);
        com_inc_s  = com_cnt_q + 4'd1;

        shift_d    = window_s;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        com_cnt_d  = com_cnt_q;
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        active_d   = active_q;

        case (state_q)
            SEARCH: begin
                data_d   = 8'h00;
                valid_d  = 1'b0;
                active_d = 1'b0;
                if (com_cnt_q == 4'd0) begin
                    // Sliding search: any comma seen defines the boundary here.
                    if (is_com_s) begin
                        bit_cnt_d = 3'd0;
                        com_cnt_d = 4'd1;
                        if (BC_TARGET == 4'd1) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            state_d  = SEARCH;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                    end
                end else if (boundary_s) begin
                    // Candidate boundary: confirm with another aligned comma or drop it.
                    if (is_com_s) begin
                        com_cnt_d = com_inc_s;
                        if (com_inc_s == BC_TARGET) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            state_d  = SEARCH;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                    end
                end else begin
                    com_cnt_d = com_cnt_q;
                end
            end
            ACTIVE: begin
                // Locked: counter free-runs, capture every boundary.
                active_d = 1'b1;
                if (boundary_s) begin
                    data_d  = window_s;
                    valid_d = !is_com_s;
                end else begin
                    data_d  = data_q;
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d   = SEARCH;
                com_cnt_d = 4'd0;
                data_d    = 8'h00;
                valid_d   = 1'b0;
                active_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= SEARCH;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

`ifdef STP_BYTE_COUNT_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;

    // Payload byte counter, stops at all-ones instead of wrapping.
    always_comb begin
        if ((state_q == ACTIVE) && boundary_s && !is_com_s && (byte_cnt_q != 16'hFFFF)) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Payload byte counter register.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            byte_cnt_q <= 16'h0000;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_rx_l1.sv
// -----------------------------------------------------------------------------
// Self-checking bench for serial_to_parallel_rx_l1. A bit-history reference
// model tracks the expected outputs; each scenario task drives the stream and
// compares the DUT against the model and against fixed expected values.
// -----------------------------------------------------------------------------
module tb_serial_to_parallel_rx_l1;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         NEED = 4;

    logic        clk_32f = 1'b0;
    logic        reset_L = 1'b0;
    logic        data_in = 1'b0;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        active;
`ifdef STP_BYTE_COUNT_EN
    logic [15:0] byte_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit         hist[$];
    int         m_last;
    int         m_run;
    logic       m_active;
    logic [7:0] m_data;
    logic       m_valid;
    int         m_bytes;

    serial_to_parallel_rx_l1 #(.COM_CHAR(8'hBC), .BC_NEEDED(4)) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef STP_BYTE_COUNT_EN
        ,
        .byte_count(byte_count)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        hist.delete();
        m_last   = 0;
        m_run    = 0;
        m_active = 1'b0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_bytes  = 0;
    endfunction

    // One bit received: window is the last 8 bits since reset (zeros before).
    function automatic void model_edge(input logic b);
        logic [7:0] win;
        int         n;
        bit         on_bnd;
        hist.push_back(b);
        n   = hist.size();
        win = 8'h00;
        for (int i = 0; i < 8; i++) if (n > i) win[i] = hist[n-1-i];
        on_bnd = (n > m_last) && (((n - m_last) % 8) == 0);
        if (!m_active) begin
            if (m_run == 0) begin
                if (win == COM) begin
                    m_run  = 1;
                    m_last = n;
                    if (m_run == NEED) m_active = 1'b1;
                end
            end else if (on_bnd) begin
                if (win == COM) begin
                    m_run++;
                    if (m_run == NEED) m_active = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end else if (on_bnd) begin
            m_data  = win;
            m_valid = (win != COM);
            if (m_valid && m_bytes < 65535) m_bytes++;
        end
    endfunction

    task automatic drive_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        model_edge(b);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive_bit(v[i]);
    endtask

    task automatic apply_reset();
        @(negedge clk_32f);
        reset_L = 1'b0;
        model_reset();
        #2;
        @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if ({data_out, valid_out, active} !== 10'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%h valid=%b active=%b, want 00/0/0", data_out, valid_out, active);
        end
        model_reset();
`ifdef STP_BYTE_COUNT_EN
        n_cmp++;
        if (byte_count !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_byte_count: got %h want 0000", byte_count);
        end
`endif
        @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    task automatic test_aligned();
        apply_reset();
        for (int k = 0; k < 3; k++) send_byte(COM);
        n_cmp++;
        if (active !== 1'b0) begin
            n_err++;
            $display("FAIL aligned_not_yet: active=%b want 0 after 3 commas", active);
        end
        send_byte(COM);
        n_cmp++;
        if ({active, valid_out, data_out} !== {1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL aligned_lock: active=%b valid=%b data=%h want 1/0/00", active, valid_out, data_out);
        end
        send_byte(8'hA5);
        n_cmp++;
        if ({data_out, valid_out} !== {8'hA5, 1'b1} || {data_out, valid_out} !== {m_data, m_valid}) begin
            n_err++;
            $display("FAIL aligned_payload: data=%h valid=%b want a5/1 (model %h/%b)", data_out, valid_out, m_data, m_valid);
        end
    endtask

    task automatic test_com_in_active();
        send_byte(COM);
        n_cmp++;
        if ({data_out, valid_out} !== {8'hBC, 1'b0}) begin
            n_err++;
            $display("FAIL active_comma: data=%h valid=%b want bc/0", data_out, valid_out);
        end
        drive_bit(1'b1);
        n_cmp++;
        if ({data_out, valid_out, active} !== {8'hBC, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL active_hold: data=%h valid=%b active=%b want bc/0/1", data_out, valid_out, active);
        end
        for (int i = 0; i < 7; i++) drive_bit(1'b1);
        n_cmp++;
        if ({data_out, valid_out} !== {8'hFF, 1'b1}) begin
            n_err++;
            $display("FAIL active_ff: data=%h valid=%b want ff/1", data_out, valid_out);
        end
    endtask

    task automatic test_stray();
        logic [2:0] s;
        apply_reset();
        s = 3'($urandom_range(0, 7));
        for (int i = 2; i >= 0; i--) drive_bit(s[i]);
        for (int k = 0; k < 4; k++) send_byte(COM);
        n_cmp++;
        if ({active, valid_out} !== 2'b10) begin
            n_err++;
            $display("FAIL stray_lock: active=%b valid=%b want 1/0", active, valid_out);
        end
        send_byte(8'h3C);
        n_cmp++;
        if ({data_out, valid_out} !== {8'h3C, 1'b1}) begin
            n_err++;
            $display("FAIL stray_payload: data=%h valid=%b want 3c/1", data_out, valid_out);
        end
    endtask

    task automatic test_broken();
        apply_reset();
        send_byte(COM);
        send_byte(COM);
        send_byte(8'h11);
        n_cmp++;
        if ({active, valid_out, data_out} !== 10'h000) begin
            n_err++;
            $display("FAIL broken_after_11: active=%b valid=%b data=%h want 0/0/00", active, valid_out, data_out);
        end
        for (int k = 0; k < 3; k++) send_byte(COM);
        n_cmp++;
        if (active !== 1'b0) begin
            n_err++;
            $display("FAIL broken_three: active=%b want 0", active);
        end
        send_byte(COM);
        n_cmp++;
        if ({active, valid_out} !== 2'b10) begin
            n_err++;
            $display("FAIL broken_lock: active=%b valid=%b want 1/0", active, valid_out);
        end
        send_byte(8'h22);
        n_cmp++;
        if ({data_out, valid_out} !== {8'h22, 1'b1}) begin
            n_err++;
            $display("FAIL broken_payload: data=%h valid=%b want 22/1", data_out, valid_out);
        end
    endtask

    task automatic test_reset_active();
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if ({data_out, valid_out, active} !== 10'h000) begin
            n_err++;
            $display("FAIL midbyte_reset: data=%h valid=%b active=%b want 00/0/0", data_out, valid_out, active);
        end
        model_reset();
        @(negedge clk_32f);
        reset_L = 1'b1;
        for (int k = 0; k < 3; k++) send_byte(COM);
        send_byte(8'h5A);
        n_cmp++;
        if ({active, valid_out} !== 2'b00) begin
            n_err++;
            $display("FAIL relock_short: active=%b valid=%b want 0/0", active, valid_out);
        end
        for (int k = 0; k < 4; k++) send_byte(COM);
        send_byte(8'h5A);
        n_cmp++;
        if ({active, valid_out, data_out} !== {1'b1, 1'b1, 8'h5A}) begin
            n_err++;
            $display("FAIL relock_payload: active=%b valid=%b data=%h want 1/1/5a", active, valid_out, data_out);
        end
    endtask

    task automatic test_byte_count();
`ifdef STP_BYTE_COUNT_EN
        logic [7:0] p;
        apply_reset();
        for (int k = 0; k < 4; k++) send_byte(COM);
        for (int k = 0; k < 3; k++) begin
            p = 8'($urandom_range(0, 255));
            if (p == COM) p = 8'h00;
            send_byte(p);
        end
        send_byte(COM);
        send_byte(COM);
        n_cmp++;
        if (byte_count !== 16'd3 || int'(byte_count) != m_bytes) begin
            n_err++;
            $display("FAIL byte_count: got %0d want 3 (model %0d)", byte_count, m_bytes);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         nb;
        int         ns;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 4) == 0) apply_reset();
            ns = $urandom_range(0, 7);
            for (int i = 0; i < ns; i++) drive_bit(1'($urandom_range(0, 1)));
            nb = $urandom_range(4, 12);
            for (int j = 0; j < nb; j++) begin
                if (j < 4 && $urandom_range(0, 1) == 1) b = COM;
                else if ($urandom_range(0, 2) == 0) b = COM;
                else b = 8'($urandom_range(0, 255));
                for (int i = 7; i >= 0; i--) begin
                    drive_bit(b[i]);
                    n_cmp++;
                    if ({data_out, valid_out, active} !== {m_data, m_valid, m_active}) begin
                        n_err++;
                        $display("FAIL random_bit: got data=%h valid=%b active=%b want %h/%b/%b",
                                 data_out, valid_out, active, m_data, m_valid, m_active);
                    end
`ifdef STP_BYTE_COUNT_EN
                    n_cmp++;
                    if (int'(byte_count) != m_bytes) begin
                        n_err++;
                        $display("FAIL random_byte_count: got %0d want %0d", byte_count, m_bytes);
                    end
`endif
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_aligned();
        test_com_in_active();
        test_stray();
        test_broken();
        test_reset_active();
        test_byte_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
